data_mem_access_ctrl: RTL and testbench
=======================================

Name: data_mem_access_ctrl

Overview:
- Responder at the MEM stage of the RV32IM pipeline.
- Consumes the 4-bit READ_WRITE memory-op code carried down the pipeline registers, plus the address and store data.
- Drives BUSYWAIT back to every pipeline register, which holds while BUSYWAIT is high.
- Runs a word-wide req/ack transaction to data memory, applies byte enables and store lane replication, and returns sign- or zero-extended load data.

Parameters:
TIMEOUT_CYCLES, 255, max cycles waiting for MEM_ACK before abort (used only with DMEM_TIMEOUT_EN)

Ports:
CLK  input  1  clock; all state updates on posedge
RESET  input  1  asynchronous, active-low reset
ADDRESS  input  32  byte address (ALU result)
WRITE_DATA  input  32  store data (rs2)
READ_WRITE  input  4  [3]=access valid; [2:0]: 000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU, 101 SB, 110 SH, 111 SW
READ_DATA  output  32  extended load result, registered
BUSYWAIT  output  1  stall request to the pipeline
MISALIGNED  output  1  misaligned access flag, combinational
BUS_ERROR  output  1  timeout abort flag; tied 0 without DMEM_TIMEOUT_EN
MEM_REQ  output  1  memory request, registered
MEM_WE  output  1  1 = write
MEM_ADDR  output  32  word-aligned address, {ADDRESS[31:2],2'b00}
MEM_WDATA  output  32  lane-replicated store data
MEM_BYTE_EN  output  4  byte lane enables
MEM_RDATA  input  32  memory read word
MEM_ACK  input  1  memory completion, one cycle high

Behaviour:
- Reset (RESET low, async): state=IDLE, READ_DATA=0, MEM_REQ=0, MEM_WE=0, MEM_ADDR=0, MEM_WDATA=0, MEM_BYTE_EN=0, BUS_ERROR=0, timeout counter=0.
- Reset mid-transaction drops MEM_REQ at once. A late MEM_ACK arriving in IDLE is ignored.
- Misaligned rule:
  - Halfword ops with ADDRESS[0]=1 are misaligned.
  - Word ops with ADDRESS[1:0]!=0 are misaligned.
- MISALIGNED = valid & misaligned.
- A misaligned op:
  - starts no transaction;
  - never raises BUSYWAIT;
  - suppresses the write;
  - leaves READ_DATA unchanged.
- States: IDLE, REQ, DONE.
- BUSYWAIT = (state==IDLE & valid & !misaligned) | (state==REQ). It is combinational, so a new op stalls in its first cycle.
- IDLE -> REQ on valid & aligned. On that edge, latch:
  - MEM_ADDR;
  - MEM_WE (1 for codes 101..111);
  - MEM_WDATA;
  - MEM_BYTE_EN.
  MEM_REQ=1 from that edge.
- REQ -> DONE on the edge where MEM_ACK=1:
  - MEM_REQ=0;
  - on a load, READ_DATA <= the extended lane of MEM_RDATA;
  - on a store, READ_DATA is held.
- DONE -> IDLE unconditionally. BUSYWAIT=0 in DONE, so the pipeline advances on the DONE->IDLE edge. The old READ_WRITE is ignored in DONE.
- Minimum latency with an ack in the first REQ cycle: 3 cycles (IDLE, REQ, DONE). Each memory wait state adds 1 cycle.
- Store lanes:
  - SB: MEM_WDATA={4{WRITE_DATA[7:0]}}, MEM_BYTE_EN=4'b0001<<ADDRESS[1:0].
  - SH: MEM_WDATA={2{WRITE_DATA[15:0]}}, MEM_BYTE_EN=ADDRESS[1]?4'b1100:4'b0011.
  - SW: MEM_WDATA=WRITE_DATA, MEM_BYTE_EN=4'b1111.
- Loads: MEM_BYTE_EN=4'b1111.
  - LB/LBU select byte ADDRESS[1:0] and sign/zero-extend.
  - LH/LHU select half ADDRESS[1] and sign/zero-extend.
- MEM_ACK outside REQ is ignored. ADDRESS, WRITE_DATA and READ_WRITE changes during REQ are ignored; the latched values rule.

Optional Feature:
- Macro DMEM_TIMEOUT_EN.
- Defined:
  - A counter runs in REQ, cleared on entry.
  - If it reaches TIMEOUT_CYCLES with no MEM_ACK: go to DONE, MEM_REQ=0, and BUS_ERROR=1 for the DONE cycle.
  - A timed-out load sets READ_DATA=32'h0000_0000.
  - An ack arriving on the same edge as the timeout wins (normal completion, BUS_ERROR=0).
- Undefined: no counter, REQ waits indefinitely, BUS_ERROR constant 0.

Test Plan:
- LW ADDRESS=0x100, MEM_RDATA=0x12345678, ack after 2 wait cycles -> BUSYWAIT high 4 cycles, MEM_ADDR=0x100, READ_DATA=0x12345678, BUSYWAIT low in DONE.
- LB ADDRESS=0x103, MEM_RDATA=0x80FF00AA -> READ_DATA=0xFFFFFF80. Repeat as LBU -> 0x00000080. LHU ADDRESS=0x102 -> 0x000080FF.
- SH ADDRESS=0x206, WRITE_DATA=0xCAFEBEEF -> MEM_WE=1, MEM_BYTE_EN=4'b1100, MEM_WDATA=0xBEEFBEEF, READ_DATA unchanged.
- LW ADDRESS=0x101 -> MISALIGNED=1, BUSYWAIT=0, MEM_REQ never asserted.
- SW issued, RESET low in second REQ cycle, ack pulsed after RESET released -> MEM_REQ=0 immediately, state IDLE, ack ignored, READ_DATA=0.
- DMEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, LW with no ack -> BUS_ERROR pulses 1 cycle after 4 REQ cycles, READ_DATA=0, BUSYWAIT drops.

Source files
------------

// File: rtl/data_mem_access_ctrl.sv
// MEM-stage data memory access controller for the RV32IM pipeline.
// Turns the pipelined READ_WRITE op code into one word-wide req/ack
// transaction, stalls the pipeline via BUSYWAIT and returns extended load data.
// Optional build macro: DMEM_TIMEOUT_EN adds a REQ-state watchdog that
// aborts after TIMEOUT_CYCLES cycles without MEM_ACK and flags BUS_ERROR.
//
// state | meaning
// IDLE  | waiting for a valid, aligned access
// REQ   | MEM_REQ high, waiting for MEM_ACK (or timeout)
// DONE  | transaction finished, BUSYWAIT low, pipeline advances
`timescale 1ns/1ps

module data_mem_access_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] ADDRESS,
    input  logic [31:0] WRITE_DATA,
    input  logic [3:0]  READ_WRITE,
    output logic [31:0] READ_DATA,
    output logic        BUSYWAIT,
    output logic        MISALIGNED,
    output logic        BUS_ERROR,
    output logic        MEM_REQ,
    output logic        MEM_WE,
    output logic [31:0] MEM_ADDR,
    output logic [31:0] MEM_WDATA,
    output logic [3:0]  MEM_BYTE_EN,
    input  logic [31:0] MEM_RDATA,
    input  logic        MEM_ACK
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        valid;
    logic [2:0]  op;
    logic        is_store;
    logic        is_half;
    logic        is_word;
    logic        misaligned;
    logic        access_start;
    logic        timeout_hit;
    logic [31:0] wdata_lane;
    logic [3:0]  be_lane;
    logic [31:0] load_ext;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [2:0]  op_q;
    logic [1:0]  addr_lo_q;

    assign valid      = READ_WRITE[3];
    assign op         = READ_WRITE[2:0];
    assign is_store   = op[2] & (op[1] | op[0]);
    assign is_half    = (op == 3'b001) | (op == 3'b100) | (op == 3'b110);
    assign is_word    = (op == 3'b010) | (op == 3'b111);
    assign misaligned = (is_half & ADDRESS[0]) | (is_word & (ADDRESS[1:0] != 2'b00));
    assign MISALIGNED = valid & misaligned;

    // Combinational so a new op stalls the pipeline in its very first cycle.
    assign access_start = (state == IDLE) & valid & ~misaligned;
    assign BUSYWAIT     = access_start | (state == REQ);

`ifdef DMEM_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt;

    // An ack on the same edge as the terminal count wins, hence the ~MEM_ACK term.
    assign timeout_hit = (state == REQ) & ~MEM_ACK
                         & (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    // REQ-cycle counter, held at zero outside REQ so it is clear on entry.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            tmo_cnt   <= '0;
            BUS_ERROR <= 1'b0;
        end else begin
            if (state != REQ)
                tmo_cnt <= '0;
            else
                tmo_cnt <= tmo_cnt + 1'b1;
            BUS_ERROR <= timeout_hit;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign BUS_ERROR   = 1'b0;
`endif

    // State register.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (access_start) state_nxt = REQ;
            REQ:     if (MEM_ACK || timeout_hit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Store lane replication and byte enables from the live op.
    always_comb begin
        wdata_lane = WRITE_DATA;
        be_lane    = 4'b1111;
        case (op)
            3'b101: begin
                wdata_lane = {4{WRITE_DATA[7:0]}};
                be_lane    = 4'b0001 << ADDRESS[1:0];
            end
            3'b110: begin
                wdata_lane = {2{WRITE_DATA[15:0]}};
                be_lane    = ADDRESS[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wdata_lane = WRITE_DATA;
                be_lane    = 4'b1111;
            end
        endcase
    end

    // Lane select and extension of the returned word, using the latched op.
    always_comb begin
        byte_sel = MEM_RDATA[7:0];
        case (addr_lo_q)
            2'd1:    byte_sel = MEM_RDATA[15:8];
            2'd2:    byte_sel = MEM_RDATA[23:16];
            2'd3:    byte_sel = MEM_RDATA[31:24];
            default: byte_sel = MEM_RDATA[7:0];
        endcase
        half_sel = addr_lo_q[1] ? MEM_RDATA[31:16] : MEM_RDATA[15:0];
        case (op_q)
            3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
            3'b011:  load_ext = {24'h0, byte_sel};
            3'b100:  load_ext = {16'h0, half_sel};
            default: load_ext = MEM_RDATA;
        endcase
    end

    // Memory-side registers: latch the access on entry to REQ, retire on ack/timeout.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            READ_DATA   <= '0;
            MEM_REQ     <= 1'b0;
            MEM_WE      <= 1'b0;
            MEM_ADDR    <= '0;
            MEM_WDATA   <= '0;
            MEM_BYTE_EN <= '0;
            op_q        <= '0;
            addr_lo_q   <= '0;
        end else if (access_start) begin
            MEM_REQ     <= 1'b1;
            MEM_WE      <= is_store;
            MEM_ADDR    <= {ADDRESS[31:2], 2'b00};
            MEM_WDATA   <= wdata_lane;
            MEM_BYTE_EN <= be_lane;
            op_q        <= op;
            addr_lo_q   <= ADDRESS[1:0];
        end else if ((state == REQ) && (MEM_ACK || timeout_hit)) begin
            MEM_REQ <= 1'b0;
            if (!MEM_WE)
                READ_DATA <= MEM_ACK ? load_ext : 32'h0000_0000;
        end
    end

endmodule

// File: tb/tb_data_mem_access_ctrl.sv
// Scoreboard bench for data_mem_access_ctrl: random and directed ops against a
// byte-level reference memory; a responder model plays the data memory.
`timescale 1ns/1ps

module tb_data_mem_access_ctrl;

`ifdef DMEM_TIMEOUT_EN
    localparam int unsigned TMO = 4;
`else
    localparam int unsigned TMO = 255;
`endif
    localparam logic [31:0] MEM_BASE  = 32'h100;
    localparam int          MEM_BYTES = 512;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic [31:0] ADDRESS = '0;
    logic [31:0] WRITE_DATA = '0;
    logic [3:0]  READ_WRITE = '0;
    logic [31:0] READ_DATA;
    logic        BUSYWAIT;
    logic        MISALIGNED;
    logic        BUS_ERROR;
    logic        MEM_REQ;
    logic        MEM_WE;
    logic [31:0] MEM_ADDR;
    logic [31:0] MEM_WDATA;
    logic [3:0]  MEM_BYTE_EN;
    logic [31:0] MEM_RDATA = '0;
    logic        MEM_ACK = 1'b0;
    logic        man_ack = 1'b0;
    logic        ack_w;

    assign ack_w = MEM_ACK | man_ack;

    always #5 CLK = ~CLK;

    data_mem_access_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .CLK(CLK), .RESET(RESET), .ADDRESS(ADDRESS), .WRITE_DATA(WRITE_DATA),
        .READ_WRITE(READ_WRITE), .READ_DATA(READ_DATA), .BUSYWAIT(BUSYWAIT),
        .MISALIGNED(MISALIGNED), .BUS_ERROR(BUS_ERROR), .MEM_REQ(MEM_REQ),
        .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
        .MEM_BYTE_EN(MEM_BYTE_EN), .MEM_RDATA(MEM_RDATA), .MEM_ACK(ack_w)
    );

    typedef struct packed {
        logic        we;
        logic        chk_wd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } req_t;

    req_t        exp_req_q[$];
    logic [31:0] exp_rd_q[$];
    logic [7:0]  ref_b[MEM_BYTES];
    logic [31:0] mem_w[MEM_BYTES/4];
    logic [31:0] last_read = '0;
    bit          auto_ack = 1'b1;
    int          force_wait = -1;
    int          last_waits = 0;
    int          total = 0;
    int          bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (byte-addressed memory) ----------------
    function automatic int op_size(input logic [2:0] op);
        case (op)
            3'd1, 3'd4, 3'd6: return 2;
            3'd2, 3'd7:       return 4;
            default:          return 1;
        endcase
    endfunction

    function automatic bit model_mis(input logic [2:0] op, input logic [31:0] a);
        return (a % 32'(op_size(op))) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] a);
        int      off  = int'(a - MEM_BASE);
        int      size = op_size(op);
        longint  v    = 0;
        longint  full = 64'd1 << (8 * size);
        for (int i = 0; i < size; i++)
            v += longint'(ref_b[off + i]) << (8 * i);
        if ((op == 3'd0 || op == 3'd1) && v >= full / 2)
            v -= full;
        return v[31:0];
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] op, input logic [31:0] wd);
        case (op)
            3'd5:    return {24'h0, wd[7:0]} * 32'h0101_0101;
            3'd6:    return {16'h0, wd[15:0]} * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [3:0] exp_be(input logic [2:0] op, input logic [31:0] a);
        case (op)
            3'd5:    return 4'(1 << (a % 4));
            3'd6:    return ((a % 4) >= 2) ? 4'hC : 4'h3;
            default: return 4'hF;
        endcase
    endfunction

    task automatic model_store(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd);
        int off = int'(a - MEM_BASE);
        for (int i = 0; i < op_size(op); i++)
            ref_b[off + i] = 8'(wd >> (8 * i));
    endtask

    task automatic set_word(input logic [31:0] a, input logic [31:0] w);
        int off = int'(a - MEM_BASE);
        mem_w[off / 4] = w;
        for (int i = 0; i < 4; i++)
            ref_b[off + i] = 8'(w >> (8 * i));
    endtask

    // ---------------- memory responder ----------------
    initial begin
        bit in_txn = 1'b0;
        int wait_left = 0;
        int idx;
        forever begin
            @(negedge CLK);
            if (MEM_ACK) begin
                MEM_ACK = 1'b0;
            end else if (MEM_REQ && auto_ack) begin
                if (!in_txn) begin
                    in_txn     = 1'b1;
                    last_waits = (force_wait >= 0) ? force_wait : int'($urandom_range(0, 3));
                    wait_left  = last_waits;
                end
                if (wait_left == 0) begin
                    idx = int'((MEM_ADDR - MEM_BASE) >> 2);
                    if (idx >= 0 && idx < MEM_BYTES / 4) begin
                        MEM_RDATA = mem_w[idx];
                        if (MEM_WE)
                            for (int b = 0; b < 4; b++)
                                if (MEM_BYTE_EN[b]) mem_w[idx][8*b +: 8] = MEM_WDATA[8*b +: 8];
                    end else begin
                        MEM_RDATA = $urandom;
                    end
                    MEM_ACK = 1'b1;
                    in_txn  = 1'b0;
                end else begin
                    wait_left--;
                end
            end
        end
    end

    // ---------------- request monitor ----------------
    initial begin
        bit   prev = 1'b0;
        req_t r;
        forever begin
            @(negedge CLK); #1;
            if (MEM_REQ && !prev) begin
                if (exp_req_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_req: got MEM_REQ=1 addr %h expected no request", MEM_ADDR);
                end else begin
                    r = exp_req_q.pop_front();
                    check("mem_we", 32'(MEM_WE), 32'(r.we));
                    check("mem_addr", MEM_ADDR, r.addr);
                    check("mem_byte_en", 32'(MEM_BYTE_EN), 32'(r.be));
                    if (r.chk_wd) check("mem_wdata", MEM_WDATA, r.wdata);
                end
            end
            prev = MEM_REQ;
        end
    end

    // ---------------- completion monitor ----------------
    initial begin
        bit pend = 1'b0;
        forever begin
            @(negedge CLK); #1;
            if (pend) begin
                if (exp_rd_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_done: got READ_DATA %h expected no completion", READ_DATA);
                end else begin
                    check("read_data", READ_DATA, exp_rd_q.pop_front());
                    check("busy_in_done", 32'(BUSYWAIT), 32'd0);
                    check("bus_err_in_done", 32'(BUS_ERROR), 32'd0);
                end
            end
            pend = MEM_REQ && ack_w;
        end
    end

    // ---------------- driver ----------------
    task automatic do_op(input bit v, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] wd, output int busy);
        bit   mis;
        req_t r;
        int   n = 0;
        ADDRESS    = a;
        WRITE_DATA = wd;
        READ_WRITE = {v, op};
        #1;
        mis = v && model_mis(op, a);
        check("misaligned", 32'(MISALIGNED), 32'(mis));
        check("busy_first", 32'(BUSYWAIT), 32'(v && !mis));
        if (v && !mis) begin
            r.we     = (op >= 3'd5);
            r.chk_wd = r.we;
            r.addr   = {a[31:2], 2'b00};
            r.wdata  = exp_wdata(op, wd);
            r.be     = exp_be(op, a);
            exp_req_q.push_back(r);
            if (r.we) model_store(op, a, wd);
            else last_read = model_load(op, a);
            exp_rd_q.push_back(last_read);
        end
        busy = BUSYWAIT ? 1 : 0;
        forever begin
            @(negedge CLK); #1;
            if (!BUSYWAIT) break;
            busy++;
            if (++n > 50) begin
                total++; bad++;
                $display("FAIL busy_timeout: got BUSYWAIT stuck high expected release");
                break;
            end
        end
        if (v && !mis) check("busy_cycles", 32'(busy), 32'(2 + last_waits));
        READ_WRITE = '0;
        @(negedge CLK); #1;
    endtask

    initial begin
        int busy;
        for (int i = 0; i < MEM_BYTES / 4; i++) set_word(MEM_BASE + 32'(4 * i), $urandom);

        // reset values
        repeat (2) @(negedge CLK);
        #1;
        check("rst_read_data", READ_DATA, 32'h0);
        check("rst_mem_req", 32'(MEM_REQ), 32'h0);
        check("rst_mem_we", 32'(MEM_WE), 32'h0);
        check("rst_mem_addr", MEM_ADDR, 32'h0);
        check("rst_mem_wdata", MEM_WDATA, 32'h0);
        check("rst_byte_en", 32'(MEM_BYTE_EN), 32'h0);
        check("rst_bus_error", 32'(BUS_ERROR), 32'h0);
        check("rst_busywait", 32'(BUSYWAIT), 32'h0);
        RESET = 1'b1;
        @(negedge CLK); #1;

        // reset in the middle of a store; late ack must be ignored
        auto_ack = 1'b0;
        exp_req_q.push_back('{we: 1'b1, chk_wd: 1'b1, addr: 32'h140, wdata: 32'h1122_3344, be: 4'hF});
        ADDRESS = 32'h140; WRITE_DATA = 32'h1122_3344; READ_WRITE = 4'b1111;
        @(negedge CLK); #1;
        @(negedge CLK); #1;
        READ_WRITE = '0;
        RESET = 1'b0;
        #1;
        check("rstmid_mem_req", 32'(MEM_REQ), 32'h0);
        check("rstmid_busy", 32'(BUSYWAIT), 32'h0);
        check("rstmid_read_data", READ_DATA, 32'h0);
        @(negedge CLK); RESET = 1'b1;
        @(negedge CLK); man_ack = 1'b1;
        @(negedge CLK); man_ack = 1'b0;
        #1;
        check("late_ack_mem_req", 32'(MEM_REQ), 32'h0);
        check("late_ack_busy", 32'(BUSYWAIT), 32'h0);
        check("late_ack_read_data", READ_DATA, 32'h0);
        last_read = '0;
        auto_ack = 1'b1;
        @(negedge CLK); #1;

        // directed loads/stores
        set_word(32'h100, 32'h1234_5678);
        force_wait = 2;
        do_op(1'b1, 3'd2, 32'h100, 32'h0, busy);
        force_wait = -1;
        check("lw_busy_4", 32'(busy), 32'd4);
        check("lw_data", READ_DATA, 32'h1234_5678);

        set_word(32'h100, 32'h80FF_00AA);
        do_op(1'b1, 3'd0, 32'h103, 32'h0, busy);
        check("lb_sign", READ_DATA, 32'hFFFF_FF80);
        do_op(1'b1, 3'd3, 32'h103, 32'h0, busy);
        check("lbu_zero", READ_DATA, 32'h0000_0080);
        do_op(1'b1, 3'd4, 32'h102, 32'h0, busy);
        check("lhu_zero", READ_DATA, 32'h0000_80FF);
        do_op(1'b1, 3'd6, 32'h206, 32'hCAFE_BEEF, busy);
        check("sh_keeps_read", READ_DATA, 32'h0000_80FF);
        do_op(1'b1, 3'd2, 32'h101, 32'h0, busy);
        check("mis_no_req", 32'(MEM_REQ), 32'h0);
        check("mis_keeps_read", READ_DATA, 32'h0000_80FF);

`ifdef DMEM_TIMEOUT_EN
        begin
            int reqc = 0;
            bit seen = 1'b0;
            auto_ack = 1'b0;
            exp_req_q.push_back('{we: 1'b0, chk_wd: 1'b0, addr: 32'h100, wdata: 32'h0, be: 4'hF});
            ADDRESS = 32'h100; READ_WRITE = 4'b1010;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge CLK); #1;
                if (MEM_REQ) reqc++;
                if (BUS_ERROR) begin
                    seen = 1'b1;
                    READ_WRITE = '0;
                    check("tmo_read_data", READ_DATA, 32'h0);
                    check("tmo_mem_req", 32'(MEM_REQ), 32'h0);
                    check("tmo_busy", 32'(BUSYWAIT), 32'h0);
                end
            end
            check("tmo_seen", 32'(seen), 32'h1);
            check("tmo_req_cycles", 32'(reqc), 32'd4);
            @(negedge CLK); #1;
            check("tmo_bus_err_pulse", 32'(BUS_ERROR), 32'h0);
            last_read = '0;
            auto_ack = 1'b1;
        end
`endif

        // randomized traffic
        for (int k = 0; k < 80; k++) begin
            bit          v  = ($urandom_range(0, 9) != 0);
            logic [2:0]  op = 3'($urandom_range(0, 7));
            logic [31:0] a  = MEM_BASE + 32'($urandom_range(0, MEM_BYTES - 4));
            logic [31:0] wd = $urandom;
            do_op(v, op, a, wd, busy);
        end

        repeat (4) @(negedge CLK);
        #1;
        check("req_q_drained", 32'(exp_req_q.size()), 32'd0);
        check("rd_q_drained", 32'(exp_rd_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected end of test");
        $fatal(1, "watchdog expired");
    end

endmodule
